router_sync_n: RTL

ROUTER_SYNC_N -- requirements
Module: router_sync_n

---
 rtl/router_pkg.sv | 21 ++
 rtl/router_sync_timer.sv | 65 ++++++
 rtl/router_sync_n.sv | 94 +++++++++
 3 files changed

// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : router_pkg
// Description : Shared defaults for the router synchroniser block: channel
//               count, header address width, timeout counter width and the
//               nominal FIFO stall timeout.
// Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

  // Default number of output channels / FIFOs
  localparam int NUM_CH_DEF  = 3;
  // Default width of the header destination address field
  localparam int ADDR_W_DEF  = 2;
  // Default width of the per-channel stall counter
  localparam int CNT_W_DEF   = 5;
  // Nominal stall timeout used by the surrounding router
  localparam int TIMEOUT_DEF = 30;

endpackage : router_pkg
`default_nettype wire

// File: rtl/router_sync_timer.sv
`default_nettype none
// ============================================================================
// Module      : router_sync_timer
// Description : One channel's stall watchdog. Counts cycles in which the FIFO
//               holds data but its reader is idle; when the count reaches
//               timeout_val a single-cycle soft_reset pulse is registered to
//               flush the FIFO. timeout_val of zero disables the watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module router_sync_timer
  import router_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             vld,
  input  logic             read_enb,
  input  logic [CNT_W-1:0] timeout_val,
  output logic             soft_reset
);

  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             soft_reset_q;
  logic             soft_reset_d;
  logic             w_stall;
  logic [CNT_W-1:0] w_last;

  assign w_stall    = vld & ~read_enb;
  // Count value that, on a further stall, completes the timeout
  assign w_last     = timeout_val - C_CNT_ONE;
  assign soft_reset = soft_reset_q;

  // Next-state for the stall counter and the flush pulse
  always_comb begin
    cnt_d        = cnt_q;
    soft_reset_d = 1'b0;
    if (!w_stall || (timeout_val == '0)) begin
      cnt_d = '0;
    end else if (cnt_q == w_last) begin
      soft_reset_d = 1'b1;
      cnt_d        = '0;
    end else if (cnt_q != C_CNT_MAX) begin
      // Saturate rather than wrap; only reachable with an out-of-range compare
      cnt_d = cnt_q + C_CNT_ONE;
    end
  end

  // Counter and pulse registers, cleared immediately by reset
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q        <= '0;
      soft_reset_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      soft_reset_q <= soft_reset_d;
    end
  end

endmodule : router_sync_timer
`default_nettype wire

// File: rtl/router_sync_n.sv
`default_nettype none
// ============================================================================
// Module      : router_sync_n
// Description : Router synchroniser. Latches the header destination address,
//               steers the FSM write strobe to one FIFO, reports the addressed
//               FIFO's full flag (forced high for illegal addresses so the FSM
//               stalls), exposes per-FIFO valid flags and runs an independent
//               stall watchdog per channel.
// Revision    : 1.0 - initial release
// ============================================================================
module router_sync_n
  import router_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              detect_add,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              write_enb_reg,
  input  logic [NUM_CH-1:0] read_enb,
  input  logic [NUM_CH-1:0] full,
  input  logic [NUM_CH-1:0] empty,
  input  logic [CNT_W-1:0]  timeout_val,
  output logic [NUM_CH-1:0] write_enb,
  output logic              fifo_full,
  output logic [NUM_CH-1:0] vld_out,
  output logic [NUM_CH-1:0] soft_reset,
  output logic              addr_err
);

  // One extra bit so NUM_CH itself is representable when 2^ADDR_W == NUM_CH
  localparam logic [ADDR_W:0] C_NUM_CH = (ADDR_W+1)'(NUM_CH);

  logic [ADDR_W-1:0] addr_reg_q;
  logic [ADDR_W-1:0] addr_reg_d;
  logic              addr_ok_q;
  logic              addr_ok_d;

  // Capture destination and its legality on a header byte, hold otherwise
  always_comb begin
    addr_reg_d = addr_reg_q;
    addr_ok_d  = addr_ok_q;
    if (detect_add) begin
      addr_reg_d = data_in;
      addr_ok_d  = ({1'b0, data_in} < C_NUM_CH);
    end
  end

  // Address registers; reset leaves the block in the illegal-address state
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_reg_q <= '0;
      addr_ok_q  <= 1'b0;
    end else begin
      addr_reg_q <= addr_reg_d;
      addr_ok_q  <= addr_ok_d;
    end
  end

  // Decode the registered address into the write strobe and selected full flag
  always_comb begin
    write_enb = '0;
    fifo_full = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr_ok_q && (addr_reg_q == ADDR_W'(i))) begin
        write_enb[i] = write_enb_reg;
        fifo_full    = full[i];
      end
    end
  end

  assign addr_err = ~addr_ok_q;
  assign vld_out  = ~empty;

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_timer
      router_sync_timer #(
        .CNT_W (CNT_W)
      ) u_timer (
        .clock       (clock),
        .resetn      (resetn),
        .vld         (vld_out[g]),
        .read_enb    (read_enb[g]),
        .timeout_val (timeout_val),
        .soft_reset  (soft_reset[g])
      );
    end
  endgenerate

endmodule : router_sync_n
`default_nettype wire
